// File: rtl/rv32i_lsu.sv
// rv32i_lsu: dwarfRV32 load/store unit.
// One access at a time; sole master of the data bus.
module rv32i_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] rsp_addr,
  output logic [31:0] baddr,
  output logic [31:0] bdi,
  output logic [1:0]  bsz,
  output logic        mwr,
  input  logic [31:0] bdo,
  input  logic        brdy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_e;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT_CYCLES);
  localparam logic       TO_EN  = (TIMEOUT_CYCLES != 0);

  state_e state_q, state_d;

  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic [31:0] rsp_addr_q, rsp_addr_d;
  logic [31:0] baddr_q, baddr_d;
  logic [31:0] bdi_q, bdi_d;
  logic [1:0]  bsz_q, bsz_d;
  logic        mwr_q, mwr_d;

  logic        illegal;
  logic        misal;
  logic        to_hit;
  logic [31:0] load_ext;

  assign req_ready = (state_q == S_IDLE);

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_addr  = rsp_addr_q;
  assign baddr     = baddr_q;
  assign bdi       = bdi_q;
  assign bsz       = bsz_q;
  assign mwr       = mwr_q;

  // Unsigned loads only exist for reads.
  always_comb begin
    illegal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b1;
    endcase
  end

  always_comb begin
    misal = 1'b0;
    unique case (1'b1)
      req_funct3[1:0] == 2'b01: misal = req_addr[0];
      req_funct3[1:0] == 2'b10: misal = |req_addr[1:0];
      default:                  misal = 1'b0;
    endcase
  end

  assign to_hit = TO_EN && ((cnt_q + 8'd1) == TO_CNT);

  always_comb begin
    load_ext = bdo;
    unique case (f3_q)
      3'b000:  load_ext = {{24{bdo[7]}}, bdo[7:0]};
      3'b001:  load_ext = {{16{bdo[15]}}, bdo[15:0]};
      3'b100:  load_ext = {24'd0, bdo[7:0]};
      3'b101:  load_ext = {16'd0, bdo[15:0]};
      default: load_ext = bdo;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = (illegal || misal) ? S_RESP : S_BUS;
        end
      end
      S_BUS: begin
        if (brdy || to_hit) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // mwr defaults low so only BUS cycles can write.
  always_comb begin
    cnt_d       = 8'd0;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_addr_d  = rsp_addr_q;
    baddr_d     = baddr_q;
    bdi_d       = bdi_q;
    bsz_d       = bsz_q;
    mwr_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d   = req_we;
          f3_d   = req_funct3;
          addr_d = req_addr;
          if (illegal || misal) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'd0;
            rsp_err_d   = illegal ? ERR_ILL : ERR_MIS;
            rsp_addr_d  = req_addr;
          end else begin
            baddr_d = req_addr;
            bdi_d   = req_wdata;
            bsz_d   = req_funct3[1:0];
            mwr_d   = req_we;
          end
        end
      end
      S_BUS: begin
        if (brdy) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'd0 : load_ext;
          rsp_err_d   = ERR_OK;
          rsp_addr_d  = addr_q;
        end else if (to_hit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = ERR_TO;
          rsp_addr_d  = addr_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
          mwr_d = we_q;
        end
      end
      S_RESP: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 8'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 2'd0;
      rsp_addr_q  <= 32'd0;
      baddr_q     <= 32'd0;
      bdi_q       <= 32'd0;
      bsz_q       <= 2'd0;
      mwr_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_addr_q  <= rsp_addr_d;
      baddr_q     <= baddr_d;
      bdi_q       <= bdi_d;
      bsz_q       <= bsz_d;
      mwr_q       <= mwr_d;
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb_rv32i_lsu: random + directed scoreboard bench
// for the rv32i_lsu load/store unit.
module tb_rv32i_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] rsp_addr;
  logic [31:0] baddr;
  logic [31:0] bdi;
  logic [1:0]  bsz;
  logic        mwr;
  logic [31:0] bdo = 32'd0;
  logic        brdy = 1'b0;

  rv32i_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_addr   (rsp_addr),
    .baddr      (baddr),
    .bdi        (bdi),
    .bsz        (bsz),
    .mwr        (mwr),
    .bdo        (bdo),
    .brdy       (brdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    logic [31:0] addr;
    int          lat;
    int          acc;
    bit          chk_bus;
    logic [31:0] baddr;
    logic [31:0] bdi;
    logic [1:0]  bsz;
  } rsp_t;

  typedef struct {
    logic [31:0] baddr;
    logic [31:0] bdi;
    logic [1:0]  bsz;
    logic        mwr;
  } bus_t;

  rsp_t rq[$];
  bus_t bq[$];

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int exp_wr = 0;
  int wr_seen = 0;
  bit bus_active = 1'b0;
  bit cur_we = 1'b0;
  logic [31:0] last_baddr = 32'd0;
  logic [31:0] last_bdi = 32'd0;
  logic [1:0]  last_bsz = 2'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  // Reference: error class from funct3 legality and natural alignment.
  function automatic logic [1:0] ref_err(bit we, logic [2:0] f3, logic [31:0] a);
    int unsigned size;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 2'b11;
    if (we && f3[2]) return 2'b11;
    size = 32'd1 << f3[1:0];
    if ((a % size) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] d);
    longint v;
    case (f3)
      3'd0: begin
        v = longint'(d & 32'hFF);
        if (v > 127) v = v - 256;
      end
      3'd1: begin
        v = longint'(d & 32'hFFFF);
        if (v > 32767) v = v - 65536;
      end
      3'd4: v = longint'(d & 32'hFF);
      3'd5: v = longint'(d & 32'hFFFF);
      default: v = longint'(d);
    endcase
    return v[31:0];
  endfunction

  task automatic do_req(input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] bv, input int k);
    rsp_t e;
    bus_t b;
    logic [1:0] er;
    int n;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      nchk++;
      nerr++;
      $display("FAIL ready_wait: req_ready stuck low, required 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    er = ref_err(we, f3, a);
    e.addr = a;
    e.acc  = cyc;
    e.chk_bus = 1'b0;
    e.baddr = last_baddr;
    e.bdi   = last_bdi;
    e.bsz   = last_bsz;
    if (er != 2'b00) begin
      e.err = er;
      e.rdata = 32'd0;
      e.lat = 1;
      e.chk_bus = 1'b1;
      rq.push_back(e);
    end else begin
      last_baddr = a;
      last_bdi   = wd;
      last_bsz   = f3[1:0];
      if (k >= TO) begin
        e.err = 2'b10;
        e.rdata = 32'd0;
        e.lat = TO + 1;
      end else begin
        e.err = 2'b00;
        e.rdata = we ? 32'd0 : ref_load(f3, bv);
        e.lat = k + 2;
        b.baddr = a;
        b.bdi = wd;
        b.bsz = f3[1:0];
        b.mwr = we;
        bq.push_back(b);
        if (we) exp_wr++;
      end
      rq.push_back(e);
      cur_we = we;
      bus_active = 1'b1;
      for (int i = 0; i < k && i < TO; i++) begin
        brdy = 1'b0;
        bdo = $urandom;
        @(posedge clk); #1;
      end
      if (k < TO) begin
        brdy = 1'b1;
        bdo = bv;
        @(posedge clk); #1;
        brdy = 1'b0;
        bdo = $urandom;
      end
      bus_active = 1'b0;
    end
    @(posedge clk); #1;
    chk("ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic reset_mid_bus();
    int n;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h8000_0000;
    req_wdata  = 32'h0000_0041;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    cur_we = 1'b1;
    bus_active = 1'b1;
    brdy = 1'b0;
    @(posedge clk); #1;
    chk("rst_mwr_before", {31'd0, mwr}, 32'd1);
    rst_n = 1'b0;
    bus_active = 1'b0;
    last_baddr = 32'd0;
    last_bdi = 32'd0;
    last_bsz = 2'd0;
    #1;
    chk("rst_mwr_async", {31'd0, mwr}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_baddr", baddr, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  // Response and bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("mwr_state", {31'd0, mwr}, {31'd0, bus_active && cur_we});
      if (mwr && brdy) wr_seen++;
      if (brdy) begin
        if (bq.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL bus_unexpected: brdy edge with no access pending");
        end else begin
          bus_t b;
          b = bq.pop_front();
          chk("bus_baddr", baddr, b.baddr);
          chk("bus_bdi", bdi, b.bdi);
          chk("bus_bsz", {30'd0, bsz}, {30'd0, b.bsz});
          chk("bus_mwr", {31'd0, mwr}, {31'd0, b.mwr});
        end
      end
      if (rsp_valid) begin
        if (rq.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL rsp_unexpected: rsp_valid with empty queue");
        end else begin
          rsp_t e;
          e = rq.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
          chk("rsp_addr", rsp_addr, e.addr);
          chk("rsp_lat", 32'(cyc + 1 - e.acc), 32'(e.lat));
          if (e.chk_bus) begin
            chk("err_baddr_hold", baddr, e.baddr);
            chk("err_bdi_hold", bdi, e.bdi);
            chk("err_bsz_hold", {30'd0, bsz}, {30'd0, e.bsz});
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit we;
    logic [2:0] f3;
    logic [31:0] a;
    int k;
    #2;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_mwr", {31'd0, mwr}, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {30'd0, rsp_err}, 32'd0);
    chk("reset_rsp_addr", rsp_addr, 32'd0);
    chk("reset_baddr", baddr, 32'd0);
    chk("reset_bdi", bdi, 32'd0);
    chk("reset_bsz", {30'd0, bsz}, 32'd0);
    #20;
    rst_n = 1'b1;

    do_req(1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0);
    do_req(1'b0, 3'd4, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0);
    do_req(1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'h5555_5555, 0);
    do_req(1'b0, 3'd2, 32'h0000_0206, 32'h0, 32'h0, 0);
    do_req(1'b0, 3'd3, 32'h0000_0300, 32'h0, 32'h0, 0);
    do_req(1'b1, 3'd4, 32'h0000_0301, 32'h0000_00AA, 32'h0, 0);
    do_req(1'b0, 3'd1, 32'h0000_0402, 32'h0, 32'h0000_8001, 1);
    do_req(1'b0, 3'd5, 32'h0000_0402, 32'h0, 32'h0000_8001, 2);
    do_req(1'b1, 3'd2, 32'h8000_0000, 32'h0000_0048, 32'h0, 3);
    do_req(1'b1, 3'd2, 32'h8000_0000, 32'h0000_0049, 32'h0, 10);
    do_req(1'b0, 3'd2, 32'h0000_0500, 32'h0, 32'hDEAD_BEEF, 4);
    reset_mid_bus();
    do_req(1'b0, 3'd2, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, 0);

    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000 | (a & 32'h3);
      if ($urandom_range(0, 7) == 0) k = $urandom_range(TO, TO + 3);
      else k = $urandom_range(0, TO - 1);
      do_req(we, f3, a, $urandom, $urandom, k);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
    chk("bus_queue_empty", 32'(bq.size()), 32'd0);
    chk("write_edges", 32'(wr_seen), 32'(exp_wr));
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/rv32i_lsu.md
# rv32i_lsu

Load/store unit between the dwarfRV32 execute stage and the data-side memory bus. Accepts one load/store request at a time, checks alignment and funct3 legality, and drives the byte-lane memory bus (baddr/bdi/bsz/mwr) until brdy. It returns sign- or zero-extended load data, or an error code, as a one-cycle response. It is the sole master of the data memory port, including the MMIO print address.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255 — cycles brdy may stay low in BUS before abort; 0 disables timeout (8-bit counter).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  LSU can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal funct3
- rsp_addr  out  32  address of the responding access (mtval source)
- baddr  out  32  bus byte address
- bdi  out  32  bus write data, right-aligned (lane shifting done downstream)
- bsz  out  2  00 byte, 01 half, 10 word (= funct3[1:0])
- mwr  out  1  bus write strobe
- bdo  in  32  bus read data, already right-shifted to bit 0
- brdy  in  1  bus completes the access on the rising edge where it is high

## Operation
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1. On req_valid:
  - Register we, funct3, addr and wdata.
  - Illegal funct3 (011, 110, 111; or 100/101 with req_we=1) -> RESP, err=11.
  - Else misaligned (half with addr[0]=1; word with addr[1:0]≠00) -> RESP, err=01.
  - Else -> BUS.
  - Error paths never touch baddr, bdi, bsz or mwr.
- BUS: baddr, bdi and bsz are registered from the request; mwr = stored we.
  - Edge with brdy=1: complete and go to RESP, err=00.
  - Load: capture bdo. Byte: bdo[7:0], sign-extend from bit 7 (LB) or zero-extend (LBU). Half: bdo[15:0], sign-extend from bit 15 (LH) or zero-extend (LHU). Word: bdo.
  - Store: rsp_rdata=0.
  - Edge with brdy=0: timeout counter +1. When the counter reaches TIMEOUT_CYCLES (nonzero), abort -> RESP, err=10, rsp_rdata=0.
- RESP: rsp_valid=1 for exactly one cycle; rsp_rdata, rsp_err and rsp_addr are valid in that cycle; next state IDLE. The counter clears on leaving BUS.
- mwr is 0 in every state except BUS. Exactly one write edge occurs per store: the brdy=1 edge. This rule protects the print MMIO (0x80000000) from duplicate characters.
- baddr, bdi and bsz hold their last values outside BUS. rsp_rdata, rsp_err and rsp_addr hold until the next response.

## Timing
- All outputs are registered except req_ready, which is decoded from state.
- Reset (asynchronous, immediate): state=IDLE, counter=0, rsp_valid=0, mwr=0. rsp_rdata, rsp_err, rsp_addr, baddr, bdi and bsz are all 0.
- Request accepted at edge T:
  - Bus is driven in cycle T→T+1.
  - With brdy=1, completion is at edge T+1, and rsp_valid is high in cycle T+1→T+2.
  - req_ready returns at T+2.
  - Minimum spacing between requests is 3 cycles.
- Error path: accept at T, rsp_valid in cycle T→T+1 (RESP entered directly), req_ready at T+1.
- brdy held low for k cycles: rsp_valid is k cycles later than the brdy=1 case.
- Timeout: abort at the edge where the count reaches TIMEOUT_CYCLES. mwr falls at that edge, so no write occurs.
- req_valid while req_ready=0 is ignored. Upstream holds the request until req_ready.
- rst_n asserted mid-BUS: mwr drops asynchronously, the access is lost and no response is produced. Upstream must discard it.

## Test plan
- LB at 0x103, bdo=0x000000F0, brdy=1 -> bsz=00, baddr=0x103, rsp_rdata=0xFFFFFFF0, err=00, rsp_valid exactly 2 cycles after accept. LBU with the same stimulus -> 0x000000F0.
- SH at 0x202, wdata=0x1234ABCD -> mwr high for exactly one edge, bsz=01, bdi=0x1234ABCD, rsp_rdata=0, err=00.
- LW at 0x206 -> rsp_err=01, rsp_addr=0x206, mwr and baddr untouched, rsp_valid 1 cycle after accept. funct3=011 -> err=11. SB with funct3=100 -> err=11.
- SW to 0x80000000, brdy low for 3 cycles then high -> exactly one mwr&brdy edge, rsp_valid 5 cycles after accept.
- TIMEOUT_CYCLES=4, brdy stuck at 0 on a store -> err=10 after 4 BUS cycles, mwr=0 thereafter, req_ready restored.
- rst_n pulsed low mid-BUS store -> mwr=0 immediately, rsp_valid never asserts, and the next request completes normally.
